univ_shift_reg: RTL and testbench

Parametrised universal shift register for the datapath lab series. It supports hold, rotate, logical and arithmetic shift, parallel load, and a multi-cycle burst-rotate with BUSY/DONE handshake. Q is tri-stated by OE without disturbing the stored contents. It is the general-purpose shift/rotate element that counters, serial links and display scanners in the design instantiate.

---
 rtl/univ_shift_reg_if.sv | 30 +++
 rtl/univ_shift_reg.sv | 98 +++++++++
 tb/tb_univ_shift_reg.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/univ_shift_reg_if.sv
// Control and status bundle for univ_shift_reg. The tri-stated Q bus stays a plain port.
interface univ_shift_reg_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
);
    logic             oe;
    logic [2:0]       s;
    logic [WIDTH-1:0] d;
    logic             sil;
    logic             sir;
    logic             start;
    logic             dir;
    logic [CNT_W-1:0] cnt;
    logic             sol;
    logic             sor;
    logic             busy;
    logic             done;

    // Driver side: issues modes and burst requests, observes status.
    modport master (
        output oe, s, d, sil, sir, start, dir, cnt,
        input  sol, sor, busy, done
    );

    // Register side.
    modport slave (
        input  oe, s, d, sil, sir, start, dir, cnt,
        output sol, sor, busy, done
    );
endinterface

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, rotate, logical/arithmetic shift, load and a
// multi-cycle burst rotate with BUSY/DONE. Q is tri-stated by OE; state is not.
module univ_shift_reg #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    univ_shift_reg_if.slave  bus,
    output logic [WIDTH-1:0] q_o
);
    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StRun  = 1'b1;

    localparam logic [2:0] ModeHold = 3'b000;
    localparam logic [2:0] ModeRol  = 3'b001;
    localparam logic [2:0] ModeRor  = 3'b010;
    localparam logic [2:0] ModeLoad = 3'b011;
    localparam logic [2:0] ModeShl  = 3'b100;
    localparam logic [2:0] ModeShr  = 3'b101;
    localparam logic [2:0] ModeAsr  = 3'b110;
    localparam logic [2:0] ModeBrst = 3'b111;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] reg_q, reg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] rol_v;
    logic [WIDTH-1:0] ror_v;

    assign rol_v = {reg_q[WIDTH-2:0], reg_q[WIDTH-1]};
    assign ror_v = {reg_q[0], reg_q[WIDTH-1:1]};

    // Next-state: mode decode while idle, one rotate per edge while a burst runs.
    always_comb begin
        state_d = state_q;
        reg_d   = reg_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        if (state_q == StRun) begin
            reg_d = dir_q ? ror_v : rol_v;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                state_d = StIdle;
                done_d  = 1'b1;
            end
        end else begin
            unique case (bus.s)
                ModeHold: reg_d = reg_q;
                ModeRol:  reg_d = rol_v;
                ModeRor:  reg_d = ror_v;
                ModeLoad: reg_d = bus.d;
                ModeShl:  reg_d = {reg_q[WIDTH-2:0], bus.sil};
                ModeShr:  reg_d = {bus.sir, reg_q[WIDTH-1:1]};
                ModeAsr:  reg_d = {reg_q[WIDTH-1], reg_q[WIDTH-1:1]};
                ModeBrst: begin
                    if (bus.start) begin
                        // A zero-length burst completes on the start edge itself.
                        if (bus.cnt == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = StRun;
                            cnt_d   = bus.cnt;
                            dir_d   = bus.dir;
                        end
                    end
                end
                default:  reg_d = reg_q;
            endcase
        end
    end

    // State registers with synchronous active-low reset; reset also aborts a burst.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            reg_q   <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
        end
    end

    assign q_o      = bus.oe ? {WIDTH{1'bz}} : reg_q;
    assign bus.sol  = reg_q[WIDTH-1];
    assign bus.sor  = reg_q[0];
    assign bus.busy = (state_q == StRun);
    assign bus.done = done_q;
endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboarded bench for univ_shift_reg (WIDTH=8, CNT_W=4).
module tb_univ_shift_reg;
    logic       clk;
    logic       rst_n;
    wire  [7:0] q;

    univ_shift_reg_if #(.WIDTH(8), .CNT_W(4)) bus ();

    univ_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus),
        .q_o    (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [7:0] r;
        logic       oe;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic [7:0] z_val;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Push the expected post-edge state, clock once, then pop and compare.
    task automatic cyc(input string tag, input logic [7:0] r, input logic b, input logic dn);
        exp_t e;
        sb.push_back('{tag: tag, r: r, oe: bus.oe, busy: b, done: dn});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_val({e.tag, ".q"}, {24'd0, q}, {24'd0, (e.oe ? z_val : e.r)});
        check_val({e.tag, ".sol"}, {31'd0, bus.sol}, {31'd0, e.r[7]});
        check_val({e.tag, ".sor"}, {31'd0, bus.sor}, {31'd0, e.r[0]});
        check_val({e.tag, ".busy"}, {31'd0, bus.busy}, {31'd0, e.busy});
        check_val({e.tag, ".done"}, {31'd0, bus.done}, {31'd0, e.done});
    endtask

    task automatic idle_in(input logic [2:0] s_v, input logic [7:0] d_v);
        bus.s     = s_v;
        bus.d     = d_v;
        bus.start = 1'b0;
    endtask

    initial begin
        z_val     = 'z;
        rst_n     = 1'b0;
        bus.oe    = 1'b0;
        bus.s     = 3'b011;
        bus.d     = 8'hFF;
        bus.sil   = 1'b0;
        bus.sir   = 1'b0;
        bus.start = 1'b0;
        bus.dir   = 1'b0;
        bus.cnt   = 4'd0;
        cyc("reset", 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Load and rotate
        idle_in(3'b011, 8'hA5); cyc("load_a5", 8'hA5, 0, 0);
        idle_in(3'b001, 8'h00); cyc("rol", 8'h4B, 0, 0);
        idle_in(3'b011, 8'hA5); cyc("reload", 8'hA5, 0, 0);
        idle_in(3'b010, 8'h00); cyc("ror", 8'hD2, 0, 0);
        idle_in(3'b000, 8'h33); cyc("hold", 8'hD2, 0, 0);

        // Shifts from 0x81
        idle_in(3'b011, 8'h81); cyc("ld81a", 8'h81, 0, 0);
        idle_in(3'b100, 8'h00); bus.sil = 1'b1; cyc("shl_sil1", 8'h03, 0, 0);
        idle_in(3'b011, 8'h81); cyc("ld81b", 8'h81, 0, 0);
        idle_in(3'b101, 8'h00); bus.sir = 1'b0; cyc("shr_sir0", 8'h40, 0, 0);
        idle_in(3'b011, 8'h81); cyc("ld81c", 8'h81, 0, 0);
        idle_in(3'b110, 8'h00); cyc("asr", 8'hC0, 0, 0);
        idle_in(3'b101, 8'h00); bus.sir = 1'b1; cyc("shr_sir1", 8'hE0, 0, 0);
        idle_in(3'b100, 8'h00); bus.sil = 1'b0; cyc("shl_sil0", 8'hC0, 0, 0);

        // START with a non-burst mode is ignored
        idle_in(3'b011, 8'h01); cyc("ld01a", 8'h01, 0, 0);
        bus.s = 3'b001; bus.start = 1'b1; bus.cnt = 4'd3; cyc("start_ign", 8'h02, 0, 0);

        // Burst left by 3 with mid-burst input churn
        idle_in(3'b011, 8'h01); cyc("ld01b", 8'h01, 0, 0);
        bus.s = 3'b111; bus.start = 1'b1; bus.dir = 1'b0; bus.cnt = 4'd3;
        cyc("b3_acc", 8'h01, 1, 0);
        bus.s = 3'b011; bus.d = 8'hFF; bus.dir = 1'b1; bus.cnt = 4'd9; bus.start = 1'b1;
        cyc("b3_r1", 8'h02, 1, 0);
        bus.s = 3'b111; bus.start = 1'b1; cyc("b3_r2", 8'h04, 1, 0);
        idle_in(3'b000, 8'h00); cyc("b3_r3", 8'h08, 0, 1);
        cyc("b3_post", 8'h08, 0, 0);

        // Burst right by 1
        idle_in(3'b011, 8'h01); cyc("ld01c", 8'h01, 0, 0);
        bus.s = 3'b111; bus.start = 1'b1; bus.dir = 1'b1; bus.cnt = 4'd1;
        cyc("b1_acc", 8'h01, 1, 0);
        idle_in(3'b000, 8'h00); cyc("b1_r1", 8'h80, 0, 1);
        cyc("b1_post", 8'h80, 0, 0);

        // Zero-length burst
        bus.s = 3'b111; bus.start = 1'b1; bus.cnt = 4'd0; cyc("b0_acc", 8'h80, 0, 1);
        idle_in(3'b000, 8'h00); cyc("b0_post", 8'h80, 0, 0);

        // Mode op accepted on the edge DONE falls
        bus.s = 3'b111; bus.start = 1'b1; bus.dir = 1'b0; bus.cnt = 4'd1;
        cyc("bb_acc", 8'h80, 1, 0);
        idle_in(3'b001, 8'h00); cyc("bb_r1", 8'h01, 0, 1);
        idle_in(3'b001, 8'h00); cyc("bb_next", 8'h02, 0, 0);

        // Output enable tri-states Q only
        idle_in(3'b011, 8'h3C); cyc("ld3c", 8'h3C, 0, 0);
        bus.oe = 1'b1; idle_in(3'b000, 8'h00); cyc("oe_hold", 8'h3C, 0, 0);
        idle_in(3'b001, 8'h00); cyc("oe_rol", 8'h78, 0, 0);
        bus.oe = 1'b0; idle_in(3'b000, 8'h00); cyc("oe_off", 8'h78, 0, 0);

        // Reset aborts a burst with no DONE
        idle_in(3'b011, 8'h01); cyc("ld01d", 8'h01, 0, 0);
        bus.s = 3'b111; bus.start = 1'b1; bus.dir = 1'b0; bus.cnt = 4'd5;
        cyc("b5_acc", 8'h01, 1, 0);
        idle_in(3'b000, 8'h00); cyc("b5_r1", 8'h02, 1, 0);
        cyc("b5_r2", 8'h04, 1, 0);
        rst_n = 1'b0; cyc("b5_rst", 8'h00, 0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) cyc("b5_quiet", 8'h00, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
